led_scan_sequencer: RTL and testbench
=====================================

// Module: led_scan_sequencer
// PURPOSE
//  Drives the LED panel controller's row interface: walks every panel and row of a
//  frame, fetches each row's 16 x 32-bit chunks from the double-buffered frame memory,
//  and loads them into the controller. Starts each row's shift/display and enforces a
//  minimum row period. Sits between the frame-memory bank and led_controller.
// PARAMETERS
//  MIN_ROW_CYCLES  1024  cycles per row, START + DWELL combined (>=2; sets refresh rate)
//  BUSY_WDOG       16    cycles after row_start within which row_busy must rise
// PORTS
//  clk                 in   1   system clock (50 MHz)
//  reset_n             in   1   asynchronous active-low reset
//  enable              in   1   run scanning; sampled only at IDLE and frame wrap
//  front_bank          in   1   bank to display; sampled at frame start
//  mem_rd_en           out  1   frame-memory read strobe
//  mem_addr            out  11  {bank, panel[1:0], row[3:0], chunk[3:0]}
//  mem_rd_data         in   32  read data, valid exactly 1 cycle after mem_rd_en
//  chunk_data          out  32  chunk to controller (= mem_rd_data, combinational)
//  chunk_addr          out  4   chunk index being written
//  chunk_write_enable  out  1   chunk write strobe
//  row_addr            out  4   current row, stable from LOAD through DWELL
//  panel_addr          out  2   current panel, stable from LOAD through DWELL
//  row_start           out  1   1-cycle pulse: controller begins shifting current row
//  row_busy            in   1   controller shifting/latching current row
//  frame_done          out  1   1-cycle pulse after last row of panel 3 completes
//  current_bank        out  1   bank latched for the frame in progress
//  stall_err           out  1   sticky: row_busy failed to rise within BUSY_WDOG
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; every output 0; row/panel/chunk counters 0.
//  States: IDLE, LOAD, START, DWELL, ADVANCE.
//  IDLE: outputs idle. enable=1 -> latch current_bank<=front_bank, panel=row=0 -> LOAD.
//  LOAD: 17 cycles, index L0..L16.
//   L0..L15: mem_rd_en=1, mem_addr={current_bank,panel,row,k}, k=0..15.
//   L1..L16: chunk_write_enable=1, chunk_addr=k-1, chunk_data=mem_rd_data.
//   Chunk order always 0..15; no gaps. L16 -> START.
//  START: row_start=1 for exactly 1 cycle; row timer:=1; busy_seen:=0; -> DWELL.
//  DWELL: timer increments per cycle; busy_seen set on any row_busy=1.
//   If timer reaches BUSY_WDOG+1 with busy_seen=0: stall_err<=1 (sticky to reset).
//   Exit when timer>=MIN_ROW_CYCLES AND row_busy=0 AND (busy_seen OR watchdog expired).
//   row_busy held high past the timer extends DWELL indefinitely (no timeout there).
//  ADVANCE (1 cycle): row+1; row 15->0 carries panel+1; panel 3->0 = frame wrap:
//   frame_done=1 this cycle; enable=1 -> current_bank<=front_bank, -> LOAD;
//   enable=0 -> IDLE (row/panel/outputs cleared). Non-wrap -> LOAD.
//  Timing: row_busy pulse shorter than MIN_ROW_CYCLES gives row_start-to-row_start
//   exactly MIN_ROW_CYCLES+18 cycles; frame = 64 rows.
//  enable deasserted mid-frame: frame completes, then IDLE. front_bank changes
//   mid-frame: ignored until wrap (no tearing).
//  row_addr/panel_addr never change between first LOAD cycle and ADVANCE.
//  Outputs other than chunk_data are registered.
// TESTING
//  1 Reset 5 cyc, enable=1, front_bank=1, memory word=addr: 16 reads addr 0x400..0x40F,
//    writes chunk_addr 0..15 data 0x400..0x40F 1 cyc later, then row_start pulse.
//  2 MIN_ROW_CYCLES=64, row_busy high 10 cyc after each row_start: row_start period
//    82 cyc; row_addr 0..15 then panel_addr+1; frame_done once per 64 rows.
//  3 row_busy held high 200 cyc (MIN=64): next ADVANCE only after row_busy falls;
//    period = 200+1+18 from row_start.
//  4 row_busy never asserted: stall_err=1 at cycle BUSY_WDOG+1 after row_start,
//    scanning continues at MIN+18 period, stall_err stays 1 until reset.
//  5 Toggle front_bank and drop enable mid-frame: mem_addr[10] unchanged until wrap,
//    frame_done pulses, FSM IDLE with all outputs 0.
//  6 Assert reset_n=0 mid-LOAD (L7): all outputs 0 same cycle; re-enable restarts
//    at panel 0 row 0 chunk 0.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// Row scan sequencer for the LED panel controller: fetches each row's 16 chunks
// from the selected frame-memory bank, starts the row and enforces the row period.
module led_scan_sequencer #(
  parameter int MIN_ROW_CYCLES = 1024,
  parameter int BUSY_WDOG      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        front_bank,
  output logic        mem_rd_en,
  output logic [10:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] chunk_data,
  output logic [3:0]  chunk_addr,
  output logic        chunk_write_enable,
  output logic [3:0]  row_addr,
  output logic [1:0]  panel_addr,
  output logic        row_start,
  input  logic        row_busy,
  output logic        frame_done,
  output logic        current_bank,
  output logic        stall_err
);

  // state   | meaning
  // IDLE    | not scanning, waiting for enable
  // LOAD    | 17 cycles: 16 reads, writes trail reads by one cycle
  // START   | row_start pulse, row timer begins at 1
  // DWELL   | hold row until period elapsed and controller is idle
  // ADVANCE | step row/panel, frame wrap handling
  typedef enum logic [2:0] {IDLE, LOAD, START, DWELL, ADVANCE} state_t;

  localparam int TW = $clog2(MIN_ROW_CYCLES + BUSY_WDOG + 2) + 1;
  localparam logic [TW-1:0] MIN_T  = TW'(MIN_ROW_CYCLES);
  localparam logic [TW-1:0] WDOG_T = TW'(BUSY_WDOG + 1);
  localparam logic [TW-1:0] TMAX   = '1;

  state_t          state_q, state_d;
  logic [4:0]      ld_q, ld_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_seen_q, busy_seen_d;
  logic            wdog_q, wdog_d;
  logic [3:0]      row_q, row_d;
  logic [1:0]      panel_q, panel_d;
  logic            bank_q, bank_d;
  logic            stall_err_q, stall_err_d;
  logic            mem_rd_en_q, mem_rd_en_d;
  logic [10:0]     mem_addr_q, mem_addr_d;
  logic            cwe_q, cwe_d;
  logic [3:0]      chunk_addr_q, chunk_addr_d;
  logic            row_start_q, row_start_d;
  logic            frame_done_q, frame_done_d;
  logic            wrap;

  assign wrap = (row_q == 4'hF) && (panel_q == 2'h3);

  always_comb begin
    state_d     = state_q;
    ld_d        = ld_q;
    timer_d     = timer_q;
    busy_seen_d = busy_seen_q;
    wdog_d      = wdog_q;
    row_d       = row_q;
    panel_d     = panel_q;
    bank_d      = bank_q;
    stall_err_d = stall_err_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
          ld_d    = '0;
          bank_d  = front_bank;
          row_d   = '0;
          panel_d = '0;
        end
      end
      LOAD: begin
        if (ld_q == 5'd16) begin
          state_d = START;
          timer_d = TW'(1);
        end else begin
          ld_d = ld_q + 5'd1;
        end
      end
      START: begin
        state_d     = DWELL;
        timer_d     = timer_q + TW'(1);
        busy_seen_d = 1'b0;
        wdog_d      = 1'b0;
      end
      DWELL: begin
        if (timer_q != TMAX) timer_d = timer_q + TW'(1);
        if (row_busy) busy_seen_d = 1'b1;
        if (timer_q == WDOG_T && !busy_seen_q && !row_busy) begin
          wdog_d      = 1'b1;
          stall_err_d = 1'b1;
        end
        // A held-high row_busy stretches the row without limit.
        if (timer_q >= MIN_T && !row_busy && (busy_seen_q || wdog_q)) state_d = ADVANCE;
      end
      ADVANCE: begin
        row_d = row_q + 4'd1;
        if (row_q == 4'hF) panel_d = panel_q + 2'd1;
        if (wrap && !enable) begin
          state_d = IDLE;
          bank_d  = 1'b0;
        end else begin
          state_d = LOAD;
          ld_d    = '0;
          if (wrap) bank_d = front_bank;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they are valid in-state.
    mem_rd_en_d  = (state_d == LOAD) && !ld_d[4];
    mem_addr_d   = mem_rd_en_d ? {bank_d, panel_d, row_d, ld_d[3:0]} : '0;
    cwe_d        = (state_d == LOAD) && (ld_d != 5'd0);
    chunk_addr_d = cwe_d ? (ld_d[3:0] - 4'd1) : '0;
    row_start_d  = (state_d == START);
    frame_done_d = (state_d == ADVANCE) && wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ld_q         <= '0;
      timer_q      <= '0;
      busy_seen_q  <= 1'b0;
      wdog_q       <= 1'b0;
      row_q        <= '0;
      panel_q      <= '0;
      bank_q       <= 1'b0;
      stall_err_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      cwe_q        <= 1'b0;
      chunk_addr_q <= '0;
      row_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_q         <= ld_d;
      timer_q      <= timer_d;
      busy_seen_q  <= busy_seen_d;
      wdog_q       <= wdog_d;
      row_q        <= row_d;
      panel_q      <= panel_d;
      bank_q       <= bank_d;
      stall_err_q  <= stall_err_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      cwe_q        <= cwe_d;
      chunk_addr_q <= chunk_addr_d;
      row_start_q  <= row_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Gated so the chunk bus reads zero whenever no write is in flight.
  assign chunk_data         = cwe_q ? mem_rd_data : '0;
  assign mem_rd_en          = mem_rd_en_q;
  assign mem_addr           = mem_addr_q;
  assign chunk_addr         = chunk_addr_q;
  assign chunk_write_enable = cwe_q;
  assign row_addr           = row_q;
  assign panel_addr         = panel_q;
  assign row_start          = row_start_q;
  assign frame_done         = frame_done_q;
  assign current_bank       = bank_q;
  assign stall_err          = stall_err_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer with a word=address frame memory model.
module tb_led_scan_sequencer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        front_bank;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_rd_data = 32'd0;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic        chunk_write_enable;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        row_start;
  logic        row_busy;
  logic        frame_done;
  logic        current_bank;
  logic        stall_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fd_count = 0;
  int busy_mode = 1;
  int last_rs = 0;

  logic [58:0] all_out;
  assign all_out = {mem_rd_en, mem_addr, chunk_data, chunk_addr, chunk_write_enable,
                    row_addr, panel_addr, row_start, frame_done, current_bank, stall_err};

  led_scan_sequencer #(.MIN_ROW_CYCLES(64), .BUSY_WDOG(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .front_bank(front_bank),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .chunk_data(chunk_data), .chunk_addr(chunk_addr),
    .chunk_write_enable(chunk_write_enable), .row_addr(row_addr),
    .panel_addr(panel_addr), .row_start(row_start), .row_busy(row_busy),
    .frame_done(frame_done), .current_bank(current_bank), .stall_err(stall_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) mem_rd_data <= mem_rd_en ? {21'd0, mem_addr} : 32'hDEAD_BEEF;

  initial forever begin
    @(negedge clk);
    if (frame_done) fd_count++;
  end

  // Controller model: mode latched at each row_start (0 none, 1 short pulse, 2 long hold).
  initial begin
    int since;
    int cur_mode;
    since = 100000;
    cur_mode = 0;
    row_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (row_start) begin
        since = 0;
        cur_mode = busy_mode;
      end else if (since < 100000) begin
        since++;
      end
      row_busy = (cur_mode == 1 && since >= 2 && since <= 11) ||
                 (cur_mode == 2 && since <= 199);
    end
  end

  task automatic wait_row_start(input int limit, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (row_start) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable = 1'b1;
    front_bank = 1'b1;
    busy_mode = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_first_row;
    int rd_cyc[16];
    int rd_n, wr_n, rs_cyc, rel;
    rd_n = 0; wr_n = 0; rs_cyc = -1;
    reset_n = 1'b1;
    rel = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (rd_n < 16) begin
          checks++;
          if (mem_addr !== 11'(11'h400 + rd_n)) begin
            errors++;
            $display("FAIL first_row_rd_addr: got %h expected %h", mem_addr, 11'(11'h400 + rd_n));
          end
          rd_cyc[rd_n] = cyc;
        end
        rd_n++;
      end
      if (chunk_write_enable) begin
        if (wr_n < 16 && wr_n < rd_n) begin
          checks++;
          if (chunk_addr !== 4'(wr_n)) begin
            errors++;
            $display("FAIL first_row_chunk_addr: got %0d expected %0d", chunk_addr, wr_n);
          end
          checks++;
          if (chunk_data !== 32'(32'h400 + wr_n)) begin
            errors++;
            $display("FAIL first_row_chunk_data: got %h expected %h", chunk_data, 32'(32'h400 + wr_n));
          end
          checks++;
          if (cyc !== rd_cyc[wr_n] + 1) begin
            errors++;
            $display("FAIL first_row_wr_latency: got %0d expected %0d", cyc - rd_cyc[wr_n], 1);
          end
        end
        wr_n++;
      end
      if (row_start) begin
        rs_cyc = cyc;
        break;
      end
    end
    checks++;
    if (rd_n !== 16) begin errors++; $display("FAIL first_row_reads: got %0d expected 16", rd_n); end
    checks++;
    if (wr_n !== 16) begin errors++; $display("FAIL first_row_writes: got %0d expected 16", wr_n); end
    checks++;
    if (rd_cyc[0] !== rel + 1) begin
      errors++; $display("FAIL first_read_cycle: got %0d expected %0d", rd_cyc[0] - rel, 1);
    end
    checks++;
    if (rs_cyc !== rel + 18) begin
      errors++; $display("FAIL first_row_start: got %0d expected %0d", rs_cyc - rel, 18);
    end
    checks++;
    if (current_bank !== 1'b1) begin errors++; $display("FAIL first_bank: got %b expected 1", current_bank); end
    last_rs = rs_cyc;
  endtask

  task automatic test_row_timing;
    int t;
    bit ok;
    fd_count = 0;
    for (int n = 1; n <= 64; n++) begin
      wait_row_start(200, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL row_timing_timeout: got none expected row %0d", n); end
      checks++;
      if (t - last_rs !== 82) begin
        errors++; $display("FAIL row_period: got %0d expected 82 (row %0d)", t - last_rs, n);
      end
      checks++;
      if (row_addr !== 4'(n % 16) || panel_addr !== 2'((n / 16) % 4)) begin
        errors++;
        $display("FAIL row_panel_addr: got %0d/%0d expected %0d/%0d", panel_addr, row_addr, (n / 16) % 4, n % 16);
      end
      if (n == 63) begin
        checks++;
        if (fd_count !== 0) begin errors++; $display("FAIL frame_done_early: got %0d expected 0", fd_count); end
      end
      last_rs = t;
    end
    checks++;
    if (fd_count !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_count); end
    checks++;
    if (current_bank !== 1'b1 || stall_err !== 1'b0) begin
      errors++; $display("FAIL frame_bank_stall: got %b%b expected 10", current_bank, stall_err);
    end
  endtask

  task automatic test_busy_extend;
    int t1, t2, t_rd;
    bit ok;
    @(negedge clk);
    busy_mode = 2;
    wait_row_start(200, t1, ok);
    checks++;
    if (!ok || t1 - last_rs !== 82) begin
      errors++; $display("FAIL busy_pre_period: got %0d expected 82", t1 - last_rs);
    end
    @(negedge clk);
    busy_mode = 1;
    t_rd = -1;
    for (int i = 0; i < 400; i++) begin
      if (mem_rd_en) begin
        t_rd = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (t_rd - t1 !== 202) begin
      errors++; $display("FAIL busy_hold_load: got %0d expected 202", t_rd - t1);
    end
    wait_row_start(300, t2, ok);
    checks++;
    if (!ok || t2 - t1 !== 219) begin
      errors++; $display("FAIL busy_hold_period: got %0d expected 219", t2 - t1);
    end
    checks++;
    if (stall_err !== 1'b0) begin errors++; $display("FAIL busy_no_stall: got %b expected 0", stall_err); end
    last_rs = t2;
  endtask

  task automatic test_enable_drop;
    int t, rd, bad;
    bit ok, seen;
    logic [58:0] acc;
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drop_first_wrap: got none expected frame_done"); end
    for (int r = 0; r < 3; r++) wait_row_start(200, t, ok);
    checks++;
    if (!ok || row_addr !== 4'd2) begin errors++; $display("FAIL drop_row: got %0d expected 2", row_addr); end
    enable = 1'b0;
    front_bank = 1'b0;
    rd = 0; bad = 0; seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        rd++;
        if (mem_addr[10] !== 1'b1) bad++;
      end
      if (frame_done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drop_wrap: got none expected frame_done"); end
    checks++;
    if (rd !== 61 * 16) begin errors++; $display("FAIL drop_reads: got %0d expected %0d", rd, 61 * 16); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL drop_bank_tear: got %0d expected 0", bad); end
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL drop_idle_outputs: got %h expected 0", all_out); end
    acc = '0;
    repeat (50) begin
      @(negedge clk);
      acc = acc | all_out;
    end
    checks++;
    if (acc !== '0) begin errors++; $display("FAIL drop_stays_idle: got %h expected 0", acc); end
  endtask

  task automatic test_stall;
    int t0, t1;
    bit ok;
    busy_mode = 0;
    front_bank = 1'b0;
    enable = 1'b1;
    wait_row_start(40, t0, ok);
    checks++;
    if (!ok || current_bank !== 1'b0) begin
      errors++; $display("FAIL stall_restart: got %b expected 0", current_bank);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (stall_err !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0", stall_err); end
    @(negedge clk);
    checks++;
    if (stall_err !== 1'b1) begin errors++; $display("FAIL stall_set: got %b expected 1", stall_err); end
    wait_row_start(200, t1, ok);
    checks++;
    if (!ok || t1 - t0 !== 82) begin errors++; $display("FAIL stall_period: got %0d expected 82", t1 - t0); end
    checks++;
    if (row_addr !== 4'd1) begin errors++; $display("FAIL stall_row: got %0d expected 1", row_addr); end
    repeat (5) @(negedge clk);
    checks++;
    if (stall_err !== 1'b1) begin errors++; $display("FAIL stall_sticky: got %b expected 1", stall_err); end
  endtask

  task automatic test_reset_mid_load;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midload_find: got none expected mem_rd_en"); end
    repeat (7) @(negedge clk);
    checks++;
    if (mem_addr !== 11'h027) begin errors++; $display("FAIL midload_l7_addr: got %h expected 027", mem_addr); end
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midload_reset_outputs: got %h expected 0", all_out); end
    repeat (3) @(negedge clk);
    front_bank = 1'b1;
    enable = 1'b1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || mem_addr !== 11'h400) begin
      errors++; $display("FAIL restart_addr: got %h expected 400", mem_addr);
    end
    checks++;
    if (row_addr !== 4'd0 || panel_addr !== 2'd0 || stall_err !== 1'b0) begin
      errors++; $display("FAIL restart_state: got %0d/%0d/%b expected 0/0/0", panel_addr, row_addr, stall_err);
    end
    @(negedge clk);
    checks++;
    if (chunk_write_enable !== 1'b1 || chunk_addr !== 4'd0 || chunk_data !== 32'h400) begin
      errors++;
      $display("FAIL restart_chunk0: got %b/%0d/%h expected 1/0/400", chunk_write_enable, chunk_addr, chunk_data);
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_row_timing();
    test_busy_extend();
    test_enable_drop();
    test_stall();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
